cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache and the data cache.
- Each cache's pmem-side interface connects here; the arbiter grants one requester at a time.
- On grant it latches that requester's line address, operation and write data, and holds them stable on the memory port until mem_resp.
- Ties are resolved round-robin, so neither cache can starve the other.

Parameters:
- s_line, 256, line width in bits (pmem data width).
- s_addr, 32, address width in bits.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- i_pmem_address  input  s_addr  I-cache line address
- i_pmem_read  input  1  I-cache line read request (I-cache never writes)
- i_pmem_rdata  output  s_line  line data to I-cache
- i_pmem_resp  output  1  completion strobe to I-cache
- d_pmem_address  input  s_addr  D-cache line address
- d_pmem_read  input  1  D-cache line read request
- d_pmem_write  input  1  D-cache line write-back request
- d_pmem_wdata  input  s_line  D-cache write-back line
- d_pmem_rdata  output  s_line  line data to D-cache
- d_pmem_resp  output  1  completion strobe to D-cache
- mem_address  output  s_addr  memory line address
- mem_read  output  1  memory read
- mem_write  output  1  memory write
- mem_wdata  output  s_line  memory write line
- mem_rdata  input  s_line  memory read line
- mem_resp  input  1  memory completion strobe

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- State machine states: IDLE, SERVE_I, SERVE_D.
- Registers: state, last_grant (I/D), lat_addr, lat_wdata, lat_rd, lat_wr.
- Reset values:
  - state=IDLE, last_grant=I (so D wins the first tie), latched registers all zero.
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, i_pmem_resp=0, d_pmem_resp=0.
- Request definitions:
  - reqI = i_pmem_read.
  - reqD = d_pmem_read | d_pmem_write.
- IDLE transitions:
  - Only reqI: go to SERVE_I; latch i_pmem_address; lat_rd=1, lat_wr=0.
  - Only reqD: go to SERVE_D; latch d_pmem_address and d_pmem_wdata; lat_rd=d_pmem_read, lat_wr=d_pmem_write.
  - Both: grant the requester that is not last_grant.
  - Neither: stay in IDLE.
  - last_grant updates at the grant edge.
- d_pmem_read and d_pmem_write asserted together is illegal. The arbiter sets lat_wr=1, lat_rd=0, and the bench flags it via assertion.
- In SERVE_I / SERVE_D:
  - mem_read=lat_rd and mem_write=lat_wr, registered and stable for the whole transaction.
  - mem_address=lat_addr, mem_wdata=lat_wdata.
  - Requester inputs are ignored after latching; a requester deasserting mid-grant does not abort the memory transaction.
- Completion:
  - i_pmem_resp = mem_resp & (state==SERVE_I), combinational.
  - d_pmem_resp = mem_resp & (state==SERVE_D), combinational.
  - The non-granted cache never sees resp.
- Read data: i_pmem_rdata and d_pmem_rdata both = mem_rdata (broadcast); only valid alongside the respective resp.
- On mem_resp: next state = IDLE; mem_read/mem_write drop at that edge.
  - There is no back-to-back grant without passing through IDLE.
  - The minimum gap between transactions is 1 IDLE cycle.
  - This guarantees the just-served cache has one cycle to deassert its request.
- Latency: request visible in IDLE at cycle t -> mem_read/mem_write high in cycle t+1. Total requester latency = memory latency + 1 cycle.
- mem_resp while in IDLE is spurious: ignored, no resp forwarded.
- Reset mid-transaction: immediate return to IDLE with all outputs low; the outstanding memory operation is abandoned. Memory is reset by the same rst.
- Write-back followed by fill from the D-cache is two separate grants. An interleaved I-cache request may win the second arbitration under round-robin. This is legal because the D-cache holds its read request.

Test Plan:
1. Lone I read: i_pmem_read=1, addr 0x00000060; memory responds after 4 cycles with rdata=0xAA..AA -> mem_read=1, mem_address=0x00000060 from next cycle; i_pmem_resp pulses 1 cycle with i_pmem_rdata=0xAA..AA; d_pmem_resp stays 0.
2. Lone D write-back: d_pmem_write=1, addr 0x00001000, wdata=0x1234..; requester drops d_pmem_write after one cycle -> mem_write held with the same addr/wdata until mem_resp; d_pmem_resp pulses once.
3. Simultaneous after reset: reqI (0x40) and reqD read (0x80) in the same cycle -> D served first; I served next after one IDLE cycle; each resp routed to the correct cache only.
4. Sustained contention: both caches re-request continuously for 6 transactions -> grants alternate D,I,D,I,D,I; no requester waits more than one other transaction.
5. Reset mid-transaction: rst asserted 2 cycles into SERVE_D -> mem_write/mem_read low and both resp low immediately; state IDLE; a subsequent I request is granted normally.
6. Spurious mem_resp in IDLE and illegal D read+write -> no resp forwarded for the spurious strobe; the illegal request issues as a write and the assertion fires.

Source files
------------

// File: rtl/cache_arbiter.sv
// ============================================================================
// cache_arbiter : round-robin share of one line-wide memory port between
//                 the I-cache and D-cache. Revision 1.0
// ============================================================================
`default_nettype none

module cache_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [s_addr-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic [s_addr-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic [s_addr-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic [s_addr-1:0] lat_addr_q,   lat_addr_d;
  logic [s_line-1:0] lat_wdata_q,  lat_wdata_d;
  logic              lat_rd_q,     lat_rd_d;
  logic              lat_wr_q,     lat_wr_d;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;

  assign req_i = i_pmem_read;
  assign req_d = d_pmem_read | d_pmem_write;

  // On a tie the side that was not served last wins.
  assign grant_d = req_d & (~req_i | (last_grant_q == GRANT_I));
  assign grant_i = req_i & ~grant_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_rd_d     = lat_rd_q;
    lat_wr_d     = lat_wr_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          lat_addr_d   = d_pmem_address;
          lat_wdata_d  = d_pmem_wdata;
          // A simultaneous read+write is resolved as a write-back.
          lat_wr_d     = d_pmem_write;
          lat_rd_d     = d_pmem_read & ~d_pmem_write;
        end else if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          lat_addr_d   = i_pmem_address;
          lat_rd_d     = 1'b1;
          lat_wr_d     = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d  = IDLE;
          lat_rd_d = 1'b0;
          lat_wr_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        lat_rd_d = 1'b0;
        lat_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_rd_q     <= 1'b0;
      lat_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_rd_q     <= lat_rd_d;
      lat_wr_q     <= lat_wr_d;
    end
  end

  assign mem_address  = lat_addr_q;
  assign mem_wdata    = lat_wdata_q;
  assign mem_read     = lat_rd_q;
  assign mem_write    = lat_wr_q;

  assign i_pmem_resp  = mem_resp & (state_q == SERVE_I);
  assign d_pmem_resp  = mem_resp & (state_q == SERVE_D);
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// tb_cache_arbiter : directed checks of grant order, latching, resp routing,
//                    reset abort and spurious/illegal request handling. Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

  localparam int S_LINE = 256;
  localparam int S_ADDR = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [S_ADDR-1:0] i_pmem_address = '0;
  logic              i_pmem_read    = 1'b0;
  logic [S_LINE-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic [S_ADDR-1:0] d_pmem_address = '0;
  logic              d_pmem_read    = 1'b0;
  logic              d_pmem_write   = 1'b0;
  logic [S_LINE-1:0] d_pmem_wdata   = '0;
  logic [S_LINE-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic [S_ADDR-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [S_LINE-1:0] mem_wdata;
  logic [S_LINE-1:0] mem_rdata = '0;
  logic              mem_resp  = 1'b0;

  int tests = 0;
  int fails = 0;
  int illegal_seen = 0;

  cache_arbiter #(.s_line(S_LINE), .s_addr(S_ADDR)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  // Protocol monitor: D-cache must never raise read and write together.
  always @(posedge clk) begin
    if (!rst && d_pmem_read && d_pmem_write) begin
      illegal_seen = illegal_seen + 1;
      $display("[TB] note: illegal D-cache read+write request observed at %0t", $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [S_LINE-1:0] obs, input logic [S_LINE-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [S_LINE-1:0] pat_a;
    logic [S_LINE-1:0] pat_5;
    logic [S_LINE-1:0] pat_w;
    logic [S_LINE-1:0] pat_x;
    pat_a = {32{8'hAA}};
    pat_5 = {32{8'h55}};
    pat_w = {8{32'h12345678}};
    pat_x = {8{32'hDEADBEEF}};

    // Reset
    tick(); tick();
    chk("rst_mem_read",  256'(mem_read),    256'd0);
    chk("rst_mem_write", 256'(mem_write),   256'd0);
    chk("rst_mem_addr",  256'(mem_address), 256'd0);
    chk("rst_mem_wdata", mem_wdata,         256'd0);
    rst = 1'b0;
    tick();

    // 1. Lone I read, memory answers on the 4th cycle of the grant
    i_pmem_address = 32'h0000_0060;
    i_pmem_read    = 1'b1;
    chk("t1_no_early_read", 256'(mem_read), 256'd0);
    tick();
    chk("t1_mem_read", 256'(mem_read),    256'd1);
    chk("t1_mem_addr", 256'(mem_address), 256'h60);
    chk("t1_mem_write", 256'(mem_write),  256'd0);
    tick(); tick(); tick();
    chk("t1_read_held", 256'(mem_read), 256'd1);
    chk("t1_i_resp_low_pre", 256'(i_pmem_resp), 256'd0);
    mem_rdata = pat_a;
    mem_resp  = 1'b1;
    #1;
    chk("t1_i_resp",  256'(i_pmem_resp), 256'd1);
    chk("t1_d_resp",  256'(d_pmem_resp), 256'd0);
    chk("t1_i_rdata", i_pmem_rdata,      pat_a);
    tick();
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    chk("t1_read_drop", 256'(mem_read),    256'd0);
    chk("t1_i_resp_end", 256'(i_pmem_resp), 256'd0);
    tick();

    // 2. Lone D write-back, requester drops its strobe after one cycle
    d_pmem_address = 32'h0000_1000;
    d_pmem_wdata   = pat_w;
    d_pmem_write   = 1'b1;
    tick();
    d_pmem_write   = 1'b0;
    d_pmem_wdata   = '0;
    d_pmem_address = '0;
    chk("t2_mem_write", 256'(mem_write), 256'd1);
    chk("t2_mem_read",  256'(mem_read),  256'd0);
    tick(); tick();
    chk("t2_write_held", 256'(mem_write),   256'd1);
    chk("t2_addr_held",  256'(mem_address), 256'h1000);
    chk("t2_wdata_held", mem_wdata,         pat_w);
    mem_resp = 1'b1;
    #1;
    chk("t2_d_resp", 256'(d_pmem_resp), 256'd1);
    chk("t2_i_resp", 256'(i_pmem_resp), 256'd0);
    tick();
    mem_resp = 1'b0;
    chk("t2_write_drop", 256'(mem_write),   256'd0);
    chk("t2_d_resp_end", 256'(d_pmem_resp), 256'd0);

    // 3. Tie straight after reset: D first, then I after one IDLE cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_pmem_address = 32'h40;
    i_pmem_read    = 1'b1;
    d_pmem_address = 32'h80;
    d_pmem_read    = 1'b1;
    tick();
    chk("t3_first_addr", 256'(mem_address), 256'h80);
    chk("t3_first_read", 256'(mem_read),    256'd1);
    mem_rdata = pat_5;
    mem_resp  = 1'b1;
    #1;
    chk("t3_d_resp",  256'(d_pmem_resp), 256'd1);
    chk("t3_i_quiet", 256'(i_pmem_resp), 256'd0);
    chk("t3_d_rdata", d_pmem_rdata,      pat_5);
    tick();
    mem_resp    = 1'b0;
    d_pmem_read = 1'b0;
    chk("t3_idle_gap", 256'(mem_read), 256'd0);
    tick();
    chk("t3_second_addr", 256'(mem_address), 256'h40);
    chk("t3_second_read", 256'(mem_read),    256'd1);
    mem_resp = 1'b1;
    #1;
    chk("t3_i_resp",  256'(i_pmem_resp), 256'd1);
    chk("t3_d_quiet", 256'(d_pmem_resp), 256'd0);
    tick();
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    tick();

    // 4. Sustained contention: grants alternate D,I,D,I,D,I
    i_pmem_address = 32'h100;
    d_pmem_address = 32'h200;
    i_pmem_read    = 1'b1;
    d_pmem_read    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      tick();
      chk($sformatf("t4_addr_%0d", k), 256'(mem_address), exp_d ? 256'h200 : 256'h100);
      mem_resp = 1'b1;
      #1;
      chk($sformatf("t4_d_resp_%0d", k), 256'(d_pmem_resp), 256'(exp_d));
      chk($sformatf("t4_i_resp_%0d", k), 256'(i_pmem_resp), 256'(!exp_d));
      tick();
      mem_resp = 1'b0;
      chk($sformatf("t4_gap_%0d", k), 256'(mem_read), 256'd0);
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    tick();

    // 5. Reset two cycles into a D write-back
    d_pmem_address = 32'h3000;
    d_pmem_wdata   = pat_x;
    d_pmem_write   = 1'b1;
    tick();
    d_pmem_write   = 1'b0;
    chk("t5_write_on", 256'(mem_write), 256'd1);
    tick(); tick();
    #2;
    rst      = 1'b1;
    mem_resp = 1'b1;
    #1;
    chk("t5_write_off", 256'(mem_write),   256'd0);
    chk("t5_read_off",  256'(mem_read),    256'd0);
    chk("t5_addr_zero", 256'(mem_address), 256'd0);
    chk("t5_d_resp",    256'(d_pmem_resp), 256'd0);
    chk("t5_i_resp",    256'(i_pmem_resp), 256'd0);
    mem_resp = 1'b0;
    tick();
    rst = 1'b0;
    i_pmem_address = 32'h500;
    i_pmem_read    = 1'b1;
    tick();
    chk("t5_i_grant_read", 256'(mem_read),    256'd1);
    chk("t5_i_grant_addr", 256'(mem_address), 256'h500);
    mem_resp = 1'b1;
    #1;
    chk("t5_i_resp", 256'(i_pmem_resp), 256'd1);
    tick();
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    tick();

    // 6. Spurious mem_resp in IDLE, then illegal D read+write
    mem_resp = 1'b1;
    #1;
    chk("t6_spur_i", 256'(i_pmem_resp), 256'd0);
    chk("t6_spur_d", 256'(d_pmem_resp), 256'd0);
    tick();
    mem_resp = 1'b0;
    chk("t6_spur_idle", 256'({mem_read, mem_write}), 256'd0);
    d_pmem_address = 32'h700;
    d_pmem_wdata   = pat_w;
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    tick();
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    chk("t6_ill_write", 256'(mem_write),   256'd1);
    chk("t6_ill_read",  256'(mem_read),    256'd0);
    chk("t6_ill_addr",  256'(mem_address), 256'h700);
    mem_resp = 1'b1;
    #1;
    chk("t6_ill_d_resp", 256'(d_pmem_resp), 256'd1);
    tick();
    mem_resp = 1'b0;
    chk("t6_ill_flagged", 256'(illegal_seen), 256'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
